aes_key_expander: RTL and testbench



---
 rtl/aes_key_expander.sv | 204 ++++++++++++++++++++
 tb/tb_aes_key_expander.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule engine. It generates one expanded word per clock
// and hands out 128-bit round keys 0..NR in order over a valid/ready interface.
module aes_key_expander #(
    parameter int unsigned NK = 4
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              start_i,
    input  logic [32*NK-1:0]  key_in_i,
    input  logic              rk_ready_i,
    output logic              rk_valid_o,
    output logic [127:0]      rk_out_o,
    output logic [3:0]        rk_index_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned NR     = NK + 6;
    localparam logic [5:0]  LastJ  = 6'(4 * NR + 3);
    localparam logic [5:0]  NkW    = 6'(NK);
    localparam logic [2:0]  NkLast = 3'(NK - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h01;
        pw  = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gf_mul(inv, pw);
            pw = gf_mul(pw, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [32*NK-1:0]   win_q, win_d;       // word 0 (LSBs) is w[j-NK], top word is w[j-1]
    logic [95:0]        col_q, col_d;
    logic [5:0]         j_q, j_d;
    logic [2:0]         jm_q, jm_d;
    logic [3:0]         rcon_idx_q, rcon_idx_d;
    logic               rk_valid_q, rk_valid_d;
    logic [127:0]       rk_out_q, rk_out_d;
    logic [3:0]         rk_index_q, rk_index_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [31:0] head, tail, sub_tail, t_word, emit_word;
    logic        key_phase, stall, handoff;

    assign head      = win_q[31:0];
    assign tail      = win_q[32*NK-1 -: 32];
    assign key_phase = (j_q < NkW);

    // SubWord is bytewise, so it commutes with RotWord and one S-box row serves both paths.
    always_comb begin
        sub_tail = sub_word(tail);
        if (key_phase) begin
            t_word = '0;
        end else if (jm_q == 3'd0) begin
            t_word = {sub_tail[23:0], sub_tail[31:24]} ^ {rcon(rcon_idx_q), 24'h0};
        end else if (NK == 8 && jm_q == 3'd4) begin
            t_word = sub_tail;
        end else begin
            t_word = tail;
        end
    end

    assign emit_word = head ^ t_word;
    assign handoff   = rk_valid_q && rk_ready_i;
    assign stall     = (j_q[1:0] == 2'd3) && rk_valid_q && !rk_ready_i;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        col_d      = col_q;
        j_d        = j_q;
        jm_d       = jm_q;
        rcon_idx_d = rcon_idx_q;
        rk_valid_d = rk_valid_q && !rk_ready_i;
        rk_out_d   = rk_out_q;
        rk_index_d = rk_index_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StRun;
                    busy_d     = 1'b1;
                    j_d        = '0;
                    jm_d       = '0;
                    rcon_idx_d = '0;
                    for (int i = 0; i < int'(NK); i++) begin
                        win_d[32*i +: 32] = key_in_i[32*(int'(NK) - i) - 1 -: 32];
                    end
                end
            end
            StRun: begin
                if (!stall) begin
                    // Key words rotate through the window unchanged, so after NK steps it
                    // holds w[0..NK-1] in order, ready for generation.
                    win_d = {emit_word, win_q[32*NK-1:32]};
                    j_d   = j_q + 6'd1;
                    jm_d  = (jm_q == NkLast) ? 3'd0 : jm_q + 3'd1;
                    if (!key_phase && jm_q == 3'd0) rcon_idx_d = rcon_idx_q + 4'd1;
                    if (j_q[1:0] == 2'd3) begin
                        rk_out_d   = {col_q[31:0], col_q[63:32], col_q[95:64], emit_word};
                        rk_valid_d = 1'b1;
                        rk_index_d = j_q[5:2];
                    end else begin
                        col_d[32*j_q[1:0] +: 32] = emit_word;
                    end
                    if (j_q == LastJ) state_d = StDrain;
                end
            end
            StDrain: begin
                if (handoff) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q    <= StIdle;
            win_q      <= '0;
            col_q      <= '0;
            j_q        <= '0;
            jm_q       <= '0;
            rcon_idx_q <= '0;
            rk_valid_q <= 1'b0;
            rk_out_q   <= '0;
            rk_index_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            col_q      <= col_d;
            j_q        <= j_d;
            jm_q       <= jm_d;
            rcon_idx_q <= rcon_idx_d;
            rk_valid_q <= rk_valid_d;
            rk_out_q   <= rk_out_d;
            rk_index_q <= rk_index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rk_valid_o = rk_valid_q;
    assign rk_out_o   = rk_out_q;
    assign rk_index_o = rk_index_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: three instances (NK=4/6/8) checked against a FIPS-197 style
// key expansion model, known-answer vectors, backpressure, start-while-busy and reset.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [2:0]   start_s, ready_s, valid_s, busy_s, done_s;
    logic [255:0] key_s      [3];
    logic [127:0] rk_out_s   [3];
    logic [3:0]   rk_index_s [3];

    always #5 clk = ~clk;

    aes_key_expander #(.NK(4)) u_dut4 (
        .clk_i(clk), .n_rst_i(n_rst), .start_i(start_s[0]), .key_in_i(key_s[0][127:0]),
        .rk_ready_i(ready_s[0]), .rk_valid_o(valid_s[0]), .rk_out_o(rk_out_s[0]),
        .rk_index_o(rk_index_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]));
    aes_key_expander #(.NK(6)) u_dut6 (
        .clk_i(clk), .n_rst_i(n_rst), .start_i(start_s[1]), .key_in_i(key_s[1][191:0]),
        .rk_ready_i(ready_s[1]), .rk_valid_o(valid_s[1]), .rk_out_o(rk_out_s[1]),
        .rk_index_o(rk_index_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]));
    aes_key_expander #(.NK(8)) u_dut8 (
        .clk_i(clk), .n_rst_i(n_rst), .start_i(start_s[2]), .key_in_i(key_s[2]),
        .rk_ready_i(ready_s[2]), .rk_valid_o(valid_s[2]), .rk_out_o(rk_out_s[2]),
        .rk_index_o(rk_index_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]));

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [15];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c63;
        c63 = 8'h63;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sb[b] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic build_model(input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- run one schedule, record handoffs ----------------
    logic [127:0] got_rk  [16];
    int           got_idx [16];
    int           got_n   [16];
    int           got_cnt, done_n, done_pulses;
    logic         busy_at_done, busy_after;

    // n counts edges after the start-accepting edge E0; sampling is on negedges.
    task automatic run_sched(input int k, input logic [255:0] key, input int stall_rk,
                             input int stall_len, input bit poke_start);
        int n, stall_left;
        bit stalled_once;
        logic [127:0] held_rk;
        logic [3:0]   held_idx;
        got_cnt = 0; done_n = -1; done_pulses = 0; stall_left = 0; stalled_once = 0;
        busy_at_done = 1'b0; busy_after = 1'b1; held_rk = '0; held_idx = '0;
        @(negedge clk);
        key_s[k] = key; start_s[k] = 1'b1; ready_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        n = 0;
        chk($sformatf("k%0d busy after start", k), 128'(busy_s[k]), 128'd1);
        while (n < 400) begin
            if (poke_start && n == 10) begin
                key_s[k] = ~key; start_s[k] = 1'b1;
            end else if (poke_start && n == 11) begin
                start_s[k] = 1'b0;
            end
            if (valid_s[k] && int'(rk_index_s[k]) == stall_rk && !stalled_once) begin
                stalled_once = 1; stall_left = stall_len;
                held_rk = rk_out_s[k]; held_idx = rk_index_s[k];
            end else if (stall_left > 0) begin
                chk($sformatf("k%0d held rk n=%0d", k, n), rk_out_s[k], held_rk);
                chk($sformatf("k%0d held idx n=%0d", k, n), 128'(rk_index_s[k]), 128'(held_idx));
                chk($sformatf("k%0d held valid n=%0d", k, n), 128'(valid_s[k]), 128'd1);
            end
            if (stall_left > 0) begin
                ready_s[k] = 1'b0; stall_left--;
            end else begin
                ready_s[k] = 1'b1;
            end
            if (valid_s[k] && ready_s[k] && got_cnt < 16) begin
                got_rk[got_cnt] = rk_out_s[k]; got_idx[got_cnt] = int'(rk_index_s[k]);
                got_n[got_cnt] = n; got_cnt++;
            end
            if (done_s[k]) begin
                done_pulses++;
                if (done_n < 0) begin
                    done_n = n; busy_at_done = busy_s[k];
                end
            end
            if (done_n >= 0 && n == done_n + 1) busy_after = busy_s[k];
            if (done_n >= 0 && n >= done_n + 3) break;
            @(negedge clk);
            n++;
        end
        ready_s[k] = 1'b1;
        chk($sformatf("k%0d done seen within budget", k), 128'(done_n >= 0), 128'd1);
    endtask

    task automatic check_sched(input int nk, input logic [255:0] key, input string tag,
                               input bit plain);
        int nr;
        nr = nk + 6;
        build_model(nk, key);
        chk({tag, " key count"}, 128'(got_cnt), 128'(nr + 1));
        for (int i = 0; i < got_cnt && i <= nr; i++) begin
            chk($sformatf("%s rk%0d", tag, i), got_rk[i], exp_rk[i]);
            chk($sformatf("%s idx%0d", tag, i), 128'(got_idx[i]), 128'(i));
        end
        if (got_cnt > 0) begin
            if (plain) begin
                chk({tag, " rk0 latency"}, 128'(got_n[0]), 128'd4);
                chk({tag, " last rk cycle"}, 128'(got_n[got_cnt-1]), 128'(4 * nr + 4));
            end
            chk({tag, " done cycle"}, 128'(done_n), 128'(got_n[got_cnt-1] + 1));
        end
        chk({tag, " done pulses"}, 128'(done_pulses), 128'd1);
        chk({tag, " busy at done"}, 128'(busy_at_done), 128'd1);
        chk({tag, " busy after done"}, 128'(busy_after), 128'd0);
    endtask

    typedef struct {
        int           nk;
        logic [255:0] key;
        int           r;
        logic [127:0] rk;
    } vec_t;

    localparam logic [255:0] Key4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] Key6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] Key8 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic int k_of(input int nk);
        return (nk == 4) ? 0 : (nk == 6) ? 1 : 2;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        logic [255:0] rkey;
        int nks [3];
        vecs[0] = '{4, Key4, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{4, Key4, 1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{4, Key4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{6, Key6, 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[4] = '{8, Key8, 2, 128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[5] = '{8, Key8, 14, 128'hfe4890d1e6188d0b046df344706c631e};
        nks[0] = 4; nks[1] = 6; nks[2] = 8;

        build_sbox();
        start_s = '0; ready_s = '1;
        for (int k = 0; k < 3; k++) key_s[k] = '0;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("k%0d reset valid", k), 128'(valid_s[k]), 128'd0);
            chk($sformatf("k%0d reset rk_out", k), rk_out_s[k], 128'd0);
            chk($sformatf("k%0d reset idx", k), 128'(rk_index_s[k]), 128'd0);
            chk($sformatf("k%0d reset busy", k), 128'(busy_s[k]), 128'd0);
            chk($sformatf("k%0d reset done", k), 128'(done_s[k]), 128'd0);
        end
        n_rst = 1'b1;

        // Known-answer vectors, full schedule also checked against the model.
        for (int v = 0; v < 6; v++) begin
            run_sched(k_of(vecs[v].nk), vecs[v].key, -1, 0, 1'b0);
            chk($sformatf("vec%0d rk%0d", v, vecs[v].r), got_rk[vecs[v].r], vecs[v].rk);
            check_sched(vecs[v].nk, vecs[v].key, $sformatf("vec%0d", v), 1'b1);
        end

        // Random keys for every key length.
        for (int t = 0; t < 9; t++) begin
            for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom();
            run_sched(k_of(nks[t % 3]), rkey, -1, 0, 1'b0);
            check_sched(nks[t % 3], rkey, $sformatf("rand%0d nk%0d", t, nks[t % 3]), 1'b1);
        end

        // Backpressure: hold rk3 for 7 cycles.
        run_sched(0, Key4, 3, 7, 1'b0);
        check_sched(4, Key4, "stall", 1'b0);
        chk("stall rk3 handoff cycle", 128'(got_n[3]), 128'd23);
        chk("stall rk4 follows handoff", 128'(got_n[4]), 128'(got_n[3] + 1));

        // Start pulsed mid-run with a different key is ignored.
        run_sched(0, Key4, -1, 0, 1'b1);
        check_sched(4, Key4, "poke", 1'b1);

        // Reset in the middle of RUN, then a fresh schedule.
        @(negedge clk);
        key_s[0] = Key4; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrun busy", 128'(busy_s[0]), 128'd1);
        chk("midrun idx", 128'(rk_index_s[0]), 128'd4);
        #1 n_rst = 1'b0;
        #1;
        chk("abort valid", 128'(valid_s[0]), 128'd0);
        chk("abort rk_out", rk_out_s[0], 128'd0);
        chk("abort idx", 128'(rk_index_s[0]), 128'd0);
        chk("abort busy", 128'(busy_s[0]), 128'd0);
        chk("abort done", 128'(done_s[0]), 128'd0);
        @(negedge clk);
        n_rst = 1'b1;
        run_sched(2, Key8, -1, 0, 1'b0);
        check_sched(8, Key8, "post-reset nk8", 1'b1);
        run_sched(0, Key4, -1, 0, 1'b0);
        check_sched(4, Key4, "post-reset nk4", 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
